// File: rtl/sipo_deserializer_if.sv
// Parallel word handshake between the deserializer and its consumer.
// The deserializer drives data/valid; the consumer drives ready.
interface sipo_deserializer_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with word sync, holding register,
// valid/ready output handshake, overrun and misalignment flags.
module sipo_deserializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic                in,
    input  logic                sync,
    input  logic                clear_overrun,
    sipo_deserializer_if.master out_if,
    output logic                overrun,
    output logic                sync_error,
    output logic [7:0]          bit_count
);

    localparam logic [7:0] LAST = 8'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       bit_count_q, bit_count_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             sync_error_q, sync_error_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             take;

    always_comb begin
        shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], in}
                            : {in, sreg_q[WIDTH-1:1]};
        // A sync on the last bit restarts the word instead of completing it
        complete = enable && !sync && (bit_count_q == LAST);
        take     = out_valid_q && out_if.out_ready;

        sreg_d       = sreg_q;
        bit_count_d  = bit_count_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        sync_error_d = enable && sync && (bit_count_q != 8'd0);

        if (enable) begin
            sreg_d = shifted;
            if (sync) begin
                bit_count_d = 8'd1;
            end else if (complete) begin
                bit_count_d = 8'd0;
            end else begin
                bit_count_d = bit_count_q + 8'd1;
            end
        end

        if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        // A new drop overrides a same-cycle clear
        if (complete) begin
            if (!out_valid_q || take) begin
                out_data_d  = shifted;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (take) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sreg_q       <= '0;
            bit_count_q  <= 8'd0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            bit_count_q  <= bit_count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            sync_error_q <= sync_error_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign overrun          = overrun_q;
    assign sync_error       = sync_error_q;
    assign bit_count        = bit_count_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: LSB-first and MSB-first instances share one stimulus
// stream; expected words flow through per-instance scoreboards.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, enable, in_bit, sync, clr, rdy;

    sipo_deserializer_if #(.WIDTH(8)) if_l ();
    sipo_deserializer_if #(.WIDTH(8)) if_m ();
    assign if_l.out_ready = rdy;
    assign if_m.out_ready = rdy;

    logic       ovr_l, serr_l, ovr_m, serr_m;
    logic [7:0] bc_l, bc_m;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .in            (in_bit),
        .sync          (sync),
        .clear_overrun (clr),
        .out_if        (if_l),
        .overrun       (ovr_l),
        .sync_error    (serr_l),
        .bit_count     (bc_l)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .in            (in_bit),
        .sync          (sync),
        .clear_overrun (clr),
        .out_if        (if_m),
        .overrun       (ovr_m),
        .sync_error    (serr_m),
        .bit_count     (bc_m)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] ql[$];
    logic [7:0] qm[$];
    int         m_cnt;
    bit         m_valid, m_ovr, m_serr;
    logic [7:0] m_dl, m_dm;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_lsb",  if_l.out_data,      m_dl);
        chk("data_msb",  if_m.out_data,      m_dm);
        chk("valid_lsb", 8'(if_l.out_valid), 8'(m_valid));
        chk("valid_msb", 8'(if_m.out_valid), 8'(m_valid));
        chk("ovr_lsb",   8'(ovr_l),          8'(m_ovr));
        chk("ovr_msb",   8'(ovr_m),          8'(m_ovr));
        chk("serr_lsb",  8'(serr_l),         8'(m_serr));
        chk("serr_msb",  8'(serr_m),         8'(m_serr));
        chk("cnt_lsb",   bc_l,               8'(m_cnt));
        chk("cnt_msb",   bc_m,               8'(m_cnt));
    endtask

    task automatic drive(input bit en, input bit b, input bit s,
                         input bit r, input bit c);
        bit comp, take, load, drop;
        enable = en; in_bit = b; sync = s; rdy = r; clr = c;
        take   = m_valid && r;
        comp   = 1'b0;
        m_serr = en && s && (m_cnt != 0);
        if (en) begin
            if (s) m_cnt = 1;
            else if (m_cnt == 7) begin
                comp  = 1'b1;
                m_cnt = 0;
            end else m_cnt++;
        end
        load = comp && (!m_valid || take);
        drop = comp && !load;
        if (c) m_ovr = 1'b0;
        if (drop) m_ovr = 1'b1;
        if (load) m_valid = 1'b1;
        else if (take) m_valid = 1'b0;
        @(posedge clk);
        #1;
        if (load) begin
            checks++;
            assert (ql.size() > 0 && qm.size() > 0) else begin
                errors++;
                $error("FAIL sb_empty: observed=%0d expected=1", ql.size());
            end
            if (ql.size() > 0) m_dl = ql.pop_front();
            if (qm.size() > 0) m_dm = qm.pop_front();
        end
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0; enable = 1'b0; in_bit = 1'b1;
        sync = 1'b1; clr = 1'b0; rdy = 1'b1;
        @(posedge clk);
        #1;
        m_cnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_serr = 1'b0;
        m_dl = 8'h00; m_dm = 8'h00;
        ql.delete();
        qm.delete();
        check_all();
        rstn = 1'b1;
    endtask

    task automatic push(input logic [7:0] wl, input logic [7:0] wm);
        ql.push_back(wl);
        qm.push_back(wm);
    endtask

    // st[i] is the i-th transmitted bit
    task automatic send_word(input logic [7:0] st, input bit use_sync,
                             input bit gaps, input bit r, input bit r_last);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2))
                    drive(1'b0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), r, 1'b0);
            end
            drive(1'b1, st[i], use_sync && (i == 0),
                  (i == 7) ? r_last : r, 1'b0);
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; in_bit = 1'b0;
        sync = 1'b0; clr = 1'b0; rdy = 1'b0;
        do_reset();
        do_reset();

        // 1,0,1,1,0,0,1,0
        push(8'h4D, 8'hB2);
        send_word(8'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("basic_lsb", if_l.out_data, 8'h4D);
        chk("basic_msb", if_m.out_data, 8'hB2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        push(8'hA5, 8'hA5);
        send_word(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("gapped", if_l.out_data, 8'hA5);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        push(8'h3C, 8'h3C);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("resync_pulse", 8'(serr_l), 8'h01);
        send_word(8'h3C >> 1 | 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        push(8'h11, 8'h88);
        send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", if_l.out_data, 8'h11);
        chk("bp_ovr", 8'(ovr_l), 8'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clear", 8'(ovr_l), 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_accept", 8'(if_l.out_valid), 8'h00);

        push(8'h12, 8'h48);
        send_word(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'h77, 8'hEE);
        send_word(8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("simul_data", if_l.out_data, 8'h77);
        chk("simul_valid", 8'(if_l.out_valid), 8'h01);
        chk("simul_ovr", 8'(ovr_l), 8'h00);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("rst_data", if_m.out_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in/parallel-out deserializer with word alignment, an output holding register and a valid/ready handshake. Shifts one bit per `enable` strobe, LSB-first or MSB-first. Realigns on a `sync` (word-start) marker and flags misalignment and overrun. Sits between serial audio/control links (I2S-style sample streams, SPI-style command links) and the parallel sample/command pipeline. Replaces bare shift registers whose output must be sampled exactly on the completion cycle.

## Interface
Parameters:
- WIDTH, 32, word length in bits; legal range 2..255.
- MSB_FIRST, 0, 0: first received bit lands in bit 0; 1: first received bit lands in bit WIDTH-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- enable  input  1  bit strobe; `in` and `sync` are sampled only when high.
- in  input  1  serial data bit.
- sync  input  1  qualified by `enable`; marks the current bit as the first bit of a new word.
- out_data  output  WIDTH  completed word (holding register).
- out_valid  output  1  `out_data` holds an unconsumed word.
- out_ready  input  1  consumer accepts `out_data` when `out_valid` and `out_ready` are both high.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- clear_overrun  input  1  clears `overrun`.
- sync_error  output  1  one-cycle pulse: `sync` arrived with a partial word pending.
- bit_count  output  8  bits accumulated in the current partial word, 0..WIDTH-1.

## Operation
- Reset (rstn=0 at an edge): shift register=0, bit_count=0, out_data=0, out_valid=0, overrun=0, sync_error=0. Reset mid-word discards the partial word and any held word.
- Shift on enable=1:
  - MSB_FIRST=0: sreg <= {in, sreg[WIDTH-1:1]}.
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], in}.
- Counting: bit_count increments by 1 per enable. When it would reach WIDTH, the word completes and bit_count wraps to 0.
- Completion word = the shifted value that includes the current `in` bit. Aligned so the first bit of the word sits in bit 0 (LSB-first) or bit WIDTH-1 (MSB-first).
- sync with enable=1:
  - The current bit is bit 0 of a new word. The partial word is discarded and bit_count <= 1.
  - If bit_count != 0 beforehand, sync_error pulses high for the next cycle.
  - If bit_count == WIDTH-1, sync wins: no word completes.
- sync with enable=0: ignored.
- Holding register, evaluated at each edge (complete = word completes this edge, take = out_valid & out_ready):
  - complete & (!out_valid | take): out_data <= word; out_valid stays/becomes 1.
  - complete & out_valid & !take: word dropped, out_data unchanged, overrun <= 1.
  - !complete & take: out_valid <= 0; out_data keeps its old value.
- overrun: cleared by clear_overrun=1. If clear_overrun and a new drop occur on the same edge, the set wins.
- out_data changes only on a load.

## Timing
- Zero extra latency: out_data/out_valid update on the same edge that samples the WIDTH-th bit.
- Maximum throughput is one word per WIDTH enables. With enable high every cycle and out_ready tied high, no word is ever dropped.
- The consumer may hold out_ready low for up to WIDTH-1 enables after out_valid rises without loss.
- sync_error is registered: high for exactly one cycle after the offending edge.
- bit_count, out_valid and overrun are registered outputs. out_ready and clear_overrun have no combinational path to any output.

## Test plan
- Basic LSB-first (WIDTH=8, MSB_FIRST=0): enable every cycle, sync on the first bit, serial 1,0,1,1,0,0,1,0 -> out_data=8'h4D and out_valid=1 after the 8th edge; bit_count returns to 0.
- MSB-first (WIDTH=8, MSB_FIRST=1): same bit stream -> out_data=8'hB2.
- Gapped enable: random 0/1 enable pattern, word 8'hA5 -> identical result. Bits sampled while enable=0 are ignored; bit_count holds during gaps.
- Resync: send 3 bits of garbage, then sync followed by 8'h3C -> sync_error pulses once, out_data=8'h3C, and no word is emitted for the garbage.
- Back-pressure: out_ready=0, send 8'h11 then 8'h22:
  - out_data stays 8'h11 and overrun=1 after the second word.
  - clear_overrun -> overrun=0.
  - out_ready=1 for one cycle -> out_valid=0.
- Simultaneous accept and complete: out_valid=1 with out_ready=1 on the completion edge of 8'h77 -> out_data=8'h77, out_valid stays 1, overrun stays 0. Then reset mid-word -> all outputs 0.
